baccarat_datapath: RTL and testbench
====================================

// Module: baccarat_datapath
// PURPOSE
// - Card-and-score datapath feeding the baccarat statemachine; consumes its six load_* strobes.
// - Holds an internal card dealer (1..13 cycling counter) and six 4-bit card registers.
// - Returns pscore, dscore and the player third-card value (pcard3) to the statemachine.
// - Drives the raw card registers out for the HEX display stage.
// PARAMETERS
// - DEAL_SEED  4'd1  dealer value after reset; legal range 1..13.
// PORTS
// - slow_clock                   in   1  sole clock; all state updates on its rising edge.
// - reset                        in   1  synchronous, active-high; sampled on slow_clock rising edge.
// - load_pcard1/2/3              in   1  each; latch the current dealer card into player slot 1/2/3.
// - load_dcard1/2/3              in   1  each; latch the current dealer card into dealer slot 1/2/3.
// - new_card                     out  4  current dealer card, 1..13.
// - pcard1_out..pcard3_out       out  4  each; raw player cards, 0 = empty, 1..13 = A..K.
// - dcard1_out..dcard3_out       out  4  each; raw dealer cards, same encoding.
// - pscore, dscore               out  4  hand totals, 0..9.
// - pcard3                       out  4  value of player card 3, 0..9; face cards and empty = 0.
// - cards_dealt                  out  3  number of load edges accepted since reset, saturates at 6.
// - seq_err                      out  1  sticky protocol-error flag.
// BEHAVIOUR
// - Reset (reset=1 at an edge):
//   - all six card registers <= 0; new_card <= DEAL_SEED; cards_dealt <= 0; seq_err <= 0.
//   - Reset overrides any load_* asserted in the same cycle.
// - Dealer: new_card advances by 1 every non-reset edge; 13 wraps to 1. 0 never appears after reset.
// - Load: a slot whose load_* is high at an edge captures the pre-edge new_card.
//   - The dealer still advances on that edge.
//   - Outputs reflect the new card one cycle after the edge (zero extra latency).
// - Card value: raw 1..9 -> 1..9; raw 10..13 -> 0; raw 0 (empty) -> 0.
// - Scores are combinational from the card registers; valid the same cycle the registers update:
//   - pscore = (v(p1)+v(p2)+v(p3)) mod 10.
//   - dscore = (v(d1)+v(d2)+v(d3)) mod 10.
//   - Internal sum width is 5 bits (max 27); reduce by repeated subtract-10 or a compare chain, not a divider.
// - pcard3 = v(pcard3_out).
// - cards_dealt: +1 on each edge with at least one load_* high; holds at 6 (no wrap).
// - seq_err <= 1, held until reset, if at an edge either:
//   - more than one load_* is high; all asserted slots still load the same card; or
//   - a load_* targets a non-empty slot; the overwrite still happens.
// - No other state; no FSM beyond dealer, counters and flag. Loads arriving after 6 cards are accepted (overwrite rule applies).
// STRUCTURE
// - Shared package bacc_pkg:
//   - constants CARD_EMPTY=4'd0, CARD_ACE=4'd1, CARD_KING=4'd13;
//   - function card_value(input [3:0]) -> [3:0];
//   - function hand_score(three cards) -> [3:0].
//   - The statemachine reuses these.
// - Sub-module card_dealer: slow_clock, reset, DEAL_SEED -> new_card (wrap counter).
// - Top holds the card registers, scoring, cards_dealt and seq_err.
// TESTING
// - Reset held 2 cycles, DEAL_SEED=1 -> all card outs 0, pscore=dscore=pcard3=0, cards_dealt=0, seq_err=0, new_card=1.
// - Free-run 13 edges after reset -> new_card sequence 1,2,..,13,1; no card register changes.
// - load_pcard1 at edge where new_card=7 -> next cycle pcard1_out=7, pscore=7, cards_dealt=1, new_card=8.
// - Player cards 8 then 7 then 13 (via load timing) -> pscore=5, pcard3=0; dealer 9 + 12 -> dscore=9.
// - load_pcard2 and load_dcard2 same edge with new_card=4 -> both slots 4, seq_err=1, stays 1 until reset.
// - Reset asserted together with load_dcard3 after 5 cards dealt -> all cleared, dcard3_out=0, new_card=DEAL_SEED.

Source files
------------

// File: rtl/baccarat_datapath_pkg.sv
// Shared card constants and scoring helpers for the baccarat datapath and statemachine.
package bacc_pkg;

    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_KING  = 4'd13;
    localparam logic [2:0] MAX_DEALT  = 3'd6;

    // Tens and face cards count zero, as does an empty slot.
    function automatic logic [3:0] card_value(input logic [3:0] raw);
        if (raw >= CARD_ACE && raw <= 4'd9) return raw;
        return 4'd0;
    endfunction

    // Sum of three values is at most 27, so two compare stages replace a divider.
    function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                              input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] sum;
        sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/baccarat_datapath_if.sv
// Load strobes from the statemachine and card/score results back to it and the display.
interface baccarat_datapath_if;

    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] new_card;
    logic [3:0] pcard1_out, pcard2_out, pcard3_out;
    logic [3:0] dcard1_out, dcard2_out, dcard3_out;
    logic [3:0] pscore, dscore, pcard3;
    logic [2:0] cards_dealt;
    logic       seq_err;

    modport master (
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  new_card,
        input  pcard1_out, pcard2_out, pcard3_out,
        input  dcard1_out, dcard2_out, dcard3_out,
        input  pscore, dscore, pcard3, cards_dealt, seq_err
    );

    modport slave (
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output new_card,
        output pcard1_out, pcard2_out, pcard3_out,
        output dcard1_out, dcard2_out, dcard3_out,
        output pscore, dscore, pcard3, cards_dealt, seq_err
    );

endinterface

// File: rtl/baccarat_datapath_dealer.sv
// Card dealer: free-running 1..13 wrap counter, restarted at DEAL_SEED on reset.
module card_dealer
    import bacc_pkg::*;
#(
    parameter logic [3:0] DEAL_SEED = 4'd1
) (
    input  logic       slow_clock,
    input  logic       reset,
    output logic [3:0] new_card
);

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            new_card <= DEAL_SEED;
        end else if (new_card >= CARD_KING || new_card == CARD_EMPTY) begin
            new_card <= CARD_ACE;
        end else begin
            new_card <= new_card + 4'd1;
        end
    end

endmodule

// File: rtl/baccarat_datapath.sv
// Card registers, hand scoring, deal counter and protocol-error flag for the baccarat game.
module baccarat_datapath
    import bacc_pkg::*;
#(
    parameter logic [3:0] DEAL_SEED = 4'd1
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    baccarat_datapath_if.slave   dp
);

    logic [3:0] new_card;
    logic [5:0] load;
    logic [5:0] occupied;
    logic [3:0] cards [6];
    logic [2:0] cards_dealt;
    logic       seq_err;
    logic       multi_load;
    logic       overwrite;

    card_dealer #(
        .DEAL_SEED (DEAL_SEED)
    ) u_dealer (
        .slow_clock (slow_clock),
        .reset      (reset),
        .new_card   (new_card)
    );

    // Slot order: player 1..3 then dealer 1..3.
    assign load = {dp.load_dcard3, dp.load_dcard2, dp.load_dcard1,
                   dp.load_pcard3, dp.load_pcard2, dp.load_pcard1};

    always_comb begin
        occupied = '0;
        for (int i = 0; i < 6; i++) begin
            occupied[i] = (cards[i] != CARD_EMPTY);
        end
    end

    assign multi_load = (load & (load - 6'd1)) != 6'd0;
    assign overwrite  = (load & occupied) != 6'd0;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                cards[i] <= CARD_EMPTY;
            end
            cards_dealt <= 3'd0;
            seq_err     <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (load[i]) cards[i] <= new_card;
            end
            if (load != 6'd0 && cards_dealt != MAX_DEALT) begin
                cards_dealt <= cards_dealt + 3'd1;
            end
            if (multi_load || overwrite) begin
                seq_err <= 1'b1;
            end
        end
    end

    assign dp.new_card    = new_card;
    assign dp.pcard1_out  = cards[0];
    assign dp.pcard2_out  = cards[1];
    assign dp.pcard3_out  = cards[2];
    assign dp.dcard1_out  = cards[3];
    assign dp.dcard2_out  = cards[4];
    assign dp.dcard3_out  = cards[5];
    assign dp.pscore      = hand_score(cards[0], cards[1], cards[2]);
    assign dp.dscore      = hand_score(cards[3], cards[4], cards[5]);
    assign dp.pcard3      = card_value(cards[2]);
    assign dp.cards_dealt = cards_dealt;
    assign dp.seq_err     = seq_err;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Directed bench for baccarat_datapath with hand-computed expectations.
module tb_baccarat_datapath;

    logic slow_clock = 1'b0;
    logic reset      = 1'b1;
    int   checks     = 0;
    int   errors     = 0;

    baccarat_datapath_if bus ();

    baccarat_datapath #(
        .DEAL_SEED (4'd1)
    ) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .dp         (bus)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic drive_loads(input logic [5:0] m);
        {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
         bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = m;
    endtask

    task automatic pulse(input logic [5:0] m);
        drive_loads(m);
        step();
        drive_loads(6'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_card(input logic [3:0] v);
        int n = 0;
        while (bus.new_card != v && n < 20) begin
            step();
            n++;
        end
        check("wait_card", {28'b0, bus.new_card}, {28'b0, v});
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_p1"}, bus.pcard1_out, 0);
        check({tag, "_p2"}, bus.pcard2_out, 0);
        check({tag, "_p3"}, bus.pcard3_out, 0);
        check({tag, "_d1"}, bus.dcard1_out, 0);
        check({tag, "_d2"}, bus.dcard2_out, 0);
        check({tag, "_d3"}, bus.dcard3_out, 0);
        check({tag, "_pscore"}, bus.pscore, 0);
        check({tag, "_dscore"}, bus.dscore, 0);
        check({tag, "_pcard3"}, bus.pcard3, 0);
        check({tag, "_dealt"}, bus.cards_dealt, 0);
        check({tag, "_err"}, bus.seq_err, 0);
        check({tag, "_newcard"}, bus.new_card, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drive_loads(6'b0);
        @(negedge slow_clock);

        do_reset();
        check_all_clear("reset");

        // Free run: 1..13 then wrap to 1; no card register moves.
        for (int k = 0; k < 14; k++) begin
            check("freerun_card", bus.new_card, (k % 13) + 1);
            check("freerun_p1", bus.pcard1_out, 0);
            if (k < 13) step();
        end

        wait_card(4'd7);
        pulse(6'b000001);
        check("load7_p1", bus.pcard1_out, 7);
        check("load7_pscore", bus.pscore, 7);
        check("load7_dealt", bus.cards_dealt, 1);
        check("load7_newcard", bus.new_card, 8);
        check("load7_err", bus.seq_err, 0);

        // Player 8,7,K -> 15 mod 10 = 5; dealer 9,Q -> 9.
        do_reset();
        wait_card(4'd8);  pulse(6'b000001);
        wait_card(4'd7);  pulse(6'b000010);
        wait_card(4'd13); pulse(6'b000100);
        wait_card(4'd9);  pulse(6'b001000);
        wait_card(4'd12); pulse(6'b010000);
        check("hand_p3raw", bus.pcard3_out, 13);
        check("hand_pscore", bus.pscore, 5);
        check("hand_pcard3", bus.pcard3, 0);
        check("hand_dscore", bus.dscore, 9);
        check("hand_dealt", bus.cards_dealt, 5);
        check("hand_err", bus.seq_err, 0);

        // Reset beats a same-cycle load.
        reset = 1'b1;
        drive_loads(6'b100000);
        step();
        drive_loads(6'b0);
        check_all_clear("rst_load");
        reset = 1'b0;

        // Two strobes on one edge: both slots load, sticky error.
        wait_card(4'd4);
        pulse(6'b010010);
        check("multi_p2", bus.pcard2_out, 4);
        check("multi_d2", bus.dcard2_out, 4);
        check("multi_err", bus.seq_err, 1);
        check("multi_dealt", bus.cards_dealt, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("multi_sticky", bus.seq_err, 1);
        end

        // Three nines: 27 mod 10 = 7.
        do_reset();
        wait_card(4'd9); pulse(6'b000001);
        wait_card(4'd9); pulse(6'b000010);
        wait_card(4'd9); pulse(6'b000100);
        check("nines_pscore", bus.pscore, 7);
        check("nines_pcard3", bus.pcard3, 9);
        check("nines_err", bus.seq_err, 0);

        // Six distinct slots, then an overwrite past saturation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pulse(6'b000001 << i);
        end
        check("six_dealt", bus.cards_dealt, 6);
        check("six_err", bus.seq_err, 0);
        check("six_pscore", bus.pscore, 6);
        check("six_dscore", bus.dscore, 5);
        check("six_d3", bus.dcard3_out, 6);
        pulse(6'b000001);
        check("ovr_p1", bus.pcard1_out, 7);
        check("ovr_dealt", bus.cards_dealt, 6);
        check("ovr_err", bus.seq_err, 1);
        check("ovr_pscore", bus.pscore, 2);
        do_reset();
        check("ovr_cleared", bus.seq_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
